interrupt_controller: RTL and testbench

Parametrised interrupt controller between the board interrupt sources (keyboard, S1–S5 buttons) and the CPU's interrupt input. Each source is synchronised to `clk`, captured as level or rising-edge, held in a pending register, gated by a software-writable mask and priority-encoded into one request plus an encoded id. The CPU takes the request, services it and returns a one-cycle acknowledge that clears the serviced edge source. The masked pending vector is also exported for the CP0 Cause.IP field.

---
 rtl/interrupt_controller.sv | 108 ++++++++++
 tb/tb_interrupt_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronised level/edge sources, pending and mask registers,
// and a fixed-priority request/acknowledge handshake towards the CPU.
module interrupt_controller #(
  parameter int unsigned       N_SRC       = 6,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [N_SRC-1:0]  EDGE_MODE   = 6'b111110,
  parameter logic [N_SRC-1:0]  MASK_RESET  = {N_SRC{1'b1}},
  parameter int unsigned       IDW         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             ack,
  output logic [N_SRC-1:0] mask_q,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] interrupt,
  output logic             int_req,
  output logic [IDW-1:0]   int_id
);

  typedef enum logic {StIdle, StReq} state_t;

  state_t           state_q;
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] s_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] pending_d;
  logic [IDW-1:0]   first_id;

  assign s         = sync_q[SYNC_STAGES-1];
  assign rise      = s & ~s_d;
  assign interrupt = pending & mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      s_d <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      s_d <= s;
    end
  end

  // Only an ack taken in REQ clears a bit; a simultaneous new edge still sets it.
  always_comb begin
    clr = '0;
    if (state_q == StReq && ack) begin
      clr[int_id] = 1'b1;
    end
    pending_d = (EDGE_MODE & (rise | (pending & ~clr))) | (~EDGE_MODE & s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      mask_q  <= MASK_RESET;
    end else begin
      pending <= pending_d;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end
    end
  end

  // Lowest index wins.
  always_comb begin
    first_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (interrupt[i]) begin
        first_id = IDW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      int_req <= 1'b0;
      int_id  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|interrupt) begin
            state_q <= StReq;
            int_req <= 1'b1;
            int_id  <= first_id;
          end
        end
        StReq: begin
          if (ack || !interrupt[int_id]) begin
            state_q <= StIdle;
            int_req <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus random traffic, checked by a
// scoreboard fed from a cycle-level behavioural model.
module tb_interrupt_controller;

  localparam int N  = 6;
  localparam int SS = 2;
  localparam logic [N-1:0] EDGE = 6'b111110;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] irq_in;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic         ack;
  logic [N-1:0] mask_q;
  logic [N-1:0] pending;
  logic [N-1:0] interrupt;
  logic         int_req;
  logic [2:0]   int_id;

  interrupt_controller #(
    .N_SRC      (N),
    .SYNC_STAGES(SS),
    .EDGE_MODE  (EDGE),
    .MASK_RESET (6'h3F),
    .IDW        (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .ack       (ack),
    .mask_q    (mask_q),
    .pending   (pending),
    .interrupt (interrupt),
    .int_req   (int_req),
    .int_id    (int_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] pend;
    logic [N-1:0] mask;
    logic         req;
    int           id;
  } exp_t;

  exp_t         exp_q[$];
  int           req_q[$];
  logic [N-1:0] hist[$];
  logic [N-1:0] m_pend;
  logic [N-1:0] m_mask;
  logic         m_req;
  int           m_id;
  int           tests = 0;
  int           fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_mask = 6'h3F;
    m_req  = 1'b0;
    m_id   = 0;
    hist.delete();
    exp_q.delete();
    req_q.delete();
  endtask

  // One clock edge of the controller: raw samples age through a delay line of depth SS.
  task automatic model_step();
    logic [N-1:0] s_b, sd_b, intr, rise, clr, np;
    s_b  = (hist.size() > SS - 1) ? hist[SS-1] : '0;
    sd_b = (hist.size() > SS) ? hist[SS] : '0;
    intr = m_pend & m_mask;
    clr  = '0;
    if (!m_req) begin
      if (intr != '0) begin
        m_req = 1'b1;
        m_id  = lowest(intr);
        req_q.push_back(m_id);
      end
    end else if (ack) begin
      clr[m_id] = 1'b1;
      m_req     = 1'b0;
    end else if (!intr[m_id]) begin
      m_req = 1'b0;
    end
    rise = s_b & ~sd_b;
    for (int i = 0; i < N; i++) begin
      np[i] = EDGE[i] ? (rise[i] | (m_pend[i] & ~clr[i])) : s_b[i];
    end
    m_pend = np;
    if (mask_we) m_mask = mask_wdata;
    hist.push_front(irq_in);
    while (hist.size() > SS + 1) void'(hist.pop_back());
    exp_q.push_back('{pend: m_pend, mask: m_mask, req: m_req, id: m_id});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Monitor: per-cycle state compare, plus an id check each time a request is presented.
  initial begin
    logic prev_req;
    exp_t e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
      end else begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_pending", pending, e.pend);
          chk("sb_mask", mask_q, e.mask);
          chk("sb_interrupt", interrupt, e.pend & e.mask);
          chk("sb_int_req", int_req, e.req);
        end
        if (int_req && !prev_req) begin
          if (req_q.size() == 0) chk("sb_unexpected_req", 1, 0);
          else chk("sb_int_id", int_id, req_q.pop_front());
        end
        prev_req = int_req;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_mask(input logic [N-1:0] v);
    mask_we    = 1'b1;
    mask_wdata = v;
    step(1);
    mask_we = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  initial begin
    int hold[N];
    rst_n      = 1'b0;
    irq_in     = 6'h3F;
    mask_we    = 1'b0;
    mask_wdata = '0;
    ack        = 1'b0;
    step(2);
    chk("rst_pending", pending, 0);
    chk("rst_int_req", int_req, 0);
    chk("rst_mask", mask_q, 6'h3F);
    chk("rst_interrupt", interrupt, 0);

    // Release: pending after edge 2, request for id 0 after edge 3.
    rst_n = 1'b1;
    step(2);
    chk("lat_pending_e1", pending, 0);
    step(1);
    chk("lat_pending_e2", pending, 6'h3F);
    chk("lat_req_e2", int_req, 0);
    step(1);
    chk("lat_req_e3", int_req, 1);
    chk("lat_id_e3", int_id, 0);

    // Asynchronous reset mid-request.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", int_req, 0);
    chk("async_rst_pending", pending, 0);
    step(1);
    irq_in = '0;
    step(1);
    rst_n = 1'b1;
    step(4);
    chk("post_rst_pending", pending, 0);
    chk("post_rst_req", int_req, 0);

    // Edge latch, then a new edge synchronised on the very ack edge.
    irq_in[2] = 1'b1;
    step(3);
    irq_in[2] = 1'b0;
    step(1);
    chk("edge_req", int_req, 1);
    chk("edge_id", int_id, 2);
    chk("edge_pending", pending, 6'h04);
    step(1);
    irq_in[2] = 1'b1;
    step(2);
    pulse_ack();
    chk("coll_pending", pending, 6'h04);
    chk("coll_gap", int_req, 0);
    step(1);
    chk("coll_req2", int_req, 1);
    chk("coll_id2", int_id, 2);
    irq_in[2] = 1'b0;
    pulse_ack();
    chk("coll_cleared", pending, 0);
    step(1);
    chk("coll_stays_low", int_req, 0);

    // Priority without preemption.
    irq_in[4] = 1'b1;
    step(3);
    irq_in[4] = 1'b0;
    step(1);
    chk("prio_id4", int_id, 4);
    irq_in[1] = 1'b1;
    step(3);
    irq_in[1] = 1'b0;
    step(1);
    chk("prio_pending", pending, 6'h12);
    chk("prio_no_preempt", int_id, 4);
    pulse_ack();
    chk("prio_gap", int_req, 0);
    chk("prio_pending_after", pending, 6'h02);
    step(1);
    chk("prio_req1", int_req, 1);
    chk("prio_id1", int_id, 1);
    pulse_ack();

    // Masking and withdrawal.
    write_mask(6'h3D);
    irq_in[1] = 1'b1;
    step(3);
    irq_in[1] = 1'b0;
    step(1);
    chk("mask_pending", pending, 6'h02);
    chk("mask_interrupt", interrupt, 0);
    chk("mask_no_req", int_req, 0);
    write_mask(6'h3F);
    step(1);
    chk("unmask_req", int_req, 1);
    chk("unmask_id", int_id, 1);
    write_mask(6'h3D);
    chk("wd_interrupt", interrupt, 0);
    step(1);
    chk("wd_req_dropped", int_req, 0);
    write_mask(6'h3F);
    step(1);
    pulse_ack();
    chk("mask_final_pending", pending, 0);

    // Random traffic: each source holds its level for 2..8 cycles.
    for (int i = 0; i < N; i++) hold[i] = 2;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          if ($urandom_range(1, 0) == 1) irq_in[i] = ~irq_in[i];
          hold[i] = $urandom_range(8, 2);
        end
      end
      ack        = (m_req && ($urandom_range(3, 0) == 0)) || ($urandom_range(31, 0) == 0);
      mask_we    = ($urandom_range(39, 0) == 0);
      mask_wdata = 6'($urandom) | 6'($urandom);
      step(1);
    end
    ack     = 1'b0;
    mask_we = 1'b0;
    irq_in  = '0;
    step(5);
    #1;
    chk("req_queue_drained", req_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
